// File: rtl/bram_pkg.sv
// Shared types and constants for the block-RAM load/store front end.
//   size_e      : access size encoding carried on req_size (reserved behaves as word)
//   lsu_state_e : front-end FSM states, also exported on the debug state port
//   MEM_WSIZE_WORD : constant driven on the RAM wsize port (RAM always writes 4 bytes)
package bram_pkg;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'd0,
        SZ_HALF = 2'd1,
        SZ_WORD = 2'd2,
        SZ_RSVD = 2'd3
    } size_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_MERGE = 2'd2,
        ST_RESP  = 2'd3
    } lsu_state_e;

    localparam logic [2:0] MEM_WSIZE_WORD = 3'd4;

    // Reserved size is handled exactly like a full word.
    function automatic logic is_word(input size_e s);
        return (s == SZ_WORD) || (s == SZ_RSVD);
    endfunction

endpackage

// File: rtl/bram_lsu_extend.sv
// Combinational load-data extender.
//   rdata_i  : 32-bit word read from the RAM, byte at the access address in [7:0]
//   size_i   : access size (byte / half / word; reserved treated as word)
//   sign_i   : 1 = sign-extend byte/half, 0 = zero-extend; ignored for words
//   ext_o    : extended 32-bit load result
module bram_lsu_extend
    import bram_pkg::*;
(
    input  logic [31:0] rdata_i,
    input  size_e       size_i,
    input  logic        sign_i,
    output logic [31:0] ext_o
);

    always_comb begin
        ext_o = rdata_i;
        case (size_i)
            SZ_BYTE: ext_o = {{24{sign_i & rdata_i[7]}}, rdata_i[7:0]};
            SZ_HALF: ext_o = {{16{sign_i & rdata_i[15]}}, rdata_i[15:0]};
            default: ext_o = rdata_i;
        endcase
    end

endmodule

// File: rtl/bram_lsu_align1.sv
// Load/store front end for a 2^AW-byte, byte-addressed 32-bit block RAM with a
// one-cycle registered read and no byte enables.
//   clock, reset_n            : single clock, synchronous active-low reset
//   req_valid/req_ready       : request handshake (one request in flight)
//   req_write/size/signed     : store/load, access size, load sign-extension
//   req_addr/req_wdata        : byte address (any alignment), LSB-justified store data
//   rsp_valid/rsp_ready       : load response handshake; rsp_data is the extended result
//   mem_raddr/waddr/wdata/wsize/wren, mem_rdata : RAM interface
//   dbg_state                 : current FSM state, for observation only
//
// Handshake rule: a transfer happens on a rising edge where valid && ready are
// both high; once raised, rsp_valid and rsp_data stay constant until that edge.
//
// Byte/half stores become read-modify-write: the RAM read is issued in the
// accept cycle and the merged word is written back in the following MERGE cycle.
module bram_lsu_align1
    import bram_pkg::*;
#(
    parameter int AW = 11,
    parameter int DW = 32
) (
    input  logic          clock,
    input  logic          reset_n,
    input  logic          req_valid,
    output logic          req_ready,
    input  logic          req_write,
    input  logic [1:0]    req_size,
    input  logic          req_signed,
    input  logic [AW-1:0] req_addr,
    input  logic [DW-1:0] req_wdata,
    output logic          rsp_valid,
    input  logic          rsp_ready,
    output logic [DW-1:0] rsp_data,
    output logic [AW-1:0] mem_raddr,
    output logic [AW-1:0] mem_waddr,
    output logic [DW-1:0] mem_wdata,
    output logic [2:0]    mem_wsize,
    output logic          mem_wren,
    input  logic [DW-1:0] mem_rdata,
    output logic [1:0]    dbg_state
);

    lsu_state_e    state_q, state_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [15:0]   wdata_q, wdata_d;   // only the low half is ever merged
    size_e         size_q, size_d;
    logic          signed_q, signed_d;
    logic [DW-1:0] rsp_data_q, rsp_data_d;

    logic          ready_raw;
    logic          wren_raw;
    logic [DW-1:0] ext_data;
    size_e         req_size_e;

    assign req_size_e = size_e'(req_size);

    bram_lsu_extend u_extend (
        .rdata_i (mem_rdata),
        .size_i  (size_q),
        .sign_i  (signed_q),
        .ext_o   (ext_data)
    );

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q    <= ST_IDLE;
            addr_q     <= '0;
            wdata_q    <= '0;
            size_q     <= SZ_BYTE;
            signed_q   <= 1'b0;
            rsp_data_q <= '0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            size_q     <= size_d;
            signed_q   <= signed_d;
            rsp_data_q <= rsp_data_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        size_d     = size_q;
        signed_d   = signed_q;
        rsp_data_d = rsp_data_q;
        ready_raw  = 1'b0;
        rsp_valid  = 1'b0;
        wren_raw   = 1'b0;
        // Outside IDLE the read address parks on the latched address.
        mem_raddr  = addr_q;
        mem_waddr  = addr_q;
        mem_wdata  = req_wdata;

        case (state_q)
            ST_IDLE: begin
                ready_raw = 1'b1;
                mem_raddr = req_addr;
                mem_waddr = req_addr;
                if (req_valid) begin
                    addr_d   = req_addr;
                    size_d   = req_size_e;
                    signed_d = req_signed;
                    wdata_d  = req_wdata[15:0];
                    if (!req_write) begin
                        state_d = ST_LOAD;
                    end else if (is_word(req_size_e)) begin
                        wren_raw = 1'b1;
                    end else begin
                        state_d = ST_MERGE;
                    end
                end
            end
            ST_LOAD: begin
                rsp_data_d = ext_data;
                state_d    = ST_RESP;
            end
            ST_MERGE: begin
                wren_raw = 1'b1;
                if (size_q == SZ_BYTE) begin
                    mem_wdata = {mem_rdata[31:8], wdata_q[7:0]};
                end else begin
                    mem_wdata = {mem_rdata[31:16], wdata_q};
                end
                state_d = ST_IDLE;
            end
            ST_RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Gating with reset_n drops any write (including a pending merge) while in reset.
    assign mem_wren  = wren_raw & reset_n;
    assign req_ready = ready_raw & reset_n;
    assign mem_wsize = MEM_WSIZE_WORD;
    assign rsp_data  = rsp_data_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_bram_lsu_align1.sv
module tb_bram_lsu_align1;

    logic        clock;
    logic        reset_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [1:0]  req_size;
    logic        req_signed;
    logic [10:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_data;
    logic [10:0] mem_raddr;
    logic [10:0] mem_waddr;
    logic [31:0] mem_wdata;
    logic [2:0]  mem_wsize;
    logic        mem_wren;
    logic [31:0] mem_rdata;
    logic [1:0]  dbg_state;

    int total = 0;
    int bad   = 0;
    int wren_seen = 0;
    logic mon_en = 1'b0;

    bram_lsu_align1 #(.AW(11), .DW(32)) dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_write  (req_write),
        .req_size   (req_size),
        .req_signed (req_signed),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_data   (rsp_data),
        .mem_raddr  (mem_raddr),
        .mem_waddr  (mem_waddr),
        .mem_wdata  (mem_wdata),
        .mem_wsize  (mem_wsize),
        .mem_wren   (mem_wren),
        .mem_rdata  (mem_rdata),
        .dbg_state  (dbg_state)
    );

    // clock / reset
    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // RAM model: 2048 bytes, wrapping 4-byte access, registered read (old data on collision)
    logic [7:0] ram [2048];

    initial begin
        for (int i = 0; i < 2048; i++) ram[i] = 8'h00;
    end

    function automatic logic [10:0] aplus(input logic [10:0] a, input logic [10:0] k);
        logic [10:0] r;
        r = a + k;
        return r;
    endfunction

    function automatic logic [31:0] rd_word(input logic [10:0] a);
        return {ram[aplus(a, 11'd3)], ram[aplus(a, 11'd2)], ram[aplus(a, 11'd1)], ram[a]};
    endfunction

    always @(posedge clock) begin
        mem_rdata <= rd_word(mem_raddr);
        if (mem_wren) begin
            ram[mem_waddr]               <= mem_wdata[7:0];
            ram[aplus(mem_waddr, 11'd1)] <= mem_wdata[15:8];
            ram[aplus(mem_waddr, 11'd2)] <= mem_wdata[23:16];
            ram[aplus(mem_waddr, 11'd3)] <= mem_wdata[31:24];
        end
        if (mon_en && mem_wren) wren_seen++;
    end

    // scoreboard-style checker
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // driver tasks
    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic wait_ready(input string tag);
        int n;
        n = 0;
        while (!req_ready && n < 20) begin
            step();
            n++;
        end
        check({tag, "_ready"}, {31'd0, req_ready}, 32'd1);
    endtask

    // Presents a request, waits for acceptance; returns #1 after the accept edge.
    task automatic issue(input string tag, input logic wr, input logic [1:0] sz, input logic sg,
                         input logic [10:0] addr, input logic [31:0] wd);
        req_write  = wr;
        req_size   = sz;
        req_signed = sg;
        req_addr   = addr;
        req_wdata  = wd;
        req_valid  = 1'b1;
        wait_ready(tag);
        step();
        req_valid  = 1'b0;
    endtask

    task automatic store(input string tag, input logic [1:0] sz, input logic [10:0] addr,
                         input logic [31:0] wd);
        issue(tag, 1'b1, sz, 1'b0, addr, wd);
        wait_ready({tag, "_done"});
    endtask

    task automatic load(input string tag, input logic [1:0] sz, input logic sg,
                        input logic [10:0] addr, input logic [31:0] exp);
        issue(tag, 1'b0, sz, sg, addr, 32'h0);
        check({tag, "_n1_valid"}, {31'd0, rsp_valid}, 32'd0);
        step();
        check({tag, "_n2_valid"}, {31'd0, rsp_valid}, 32'd1);
        check({tag, "_data"}, rsp_data, exp);
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
        check({tag, "_idle"}, {31'd0, req_ready}, 32'd1);
    endtask

    initial begin
        logic [31:0] held;
        reset_n    = 1'b0;
        req_valid  = 1'b0;
        req_write  = 1'b0;
        req_size   = 2'd0;
        req_signed = 1'b0;
        req_addr   = 11'd0;
        req_wdata  = 32'd0;
        rsp_ready  = 1'b0;

        // reset state, with a word store attempt presented during reset
        req_valid = 1'b1;
        req_write = 1'b1;
        req_size  = 2'd2;
        req_addr  = 11'h100;
        req_wdata = 32'hFFFF_FFFF;
        step(); step(); step();
        check("rst_req_ready", {31'd0, req_ready}, 32'd0);
        check("rst_wren", {31'd0, mem_wren}, 32'd0);
        check("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        check("rst_rsp_data", rsp_data, 32'h0);
        check("rst_state", {30'd0, dbg_state}, 32'd0);
        check("wsize", {29'd0, mem_wsize}, 32'd4);
        req_valid = 1'b0;
        reset_n   = 1'b1;
        step();
        check("post_rst_ready", {31'd0, req_ready}, 32'd1);
        check("rst_no_write", rd_word(11'h100), 32'h0);

        // word store / load
        store("st_w4", 2'd2, 11'h004, 32'hDEAD_BEEF);
        load("ld_w4", 2'd2, 1'b0, 11'h004, 32'hDEAD_BEEF);

        // byte store over the word, neighbours preserved
        store("st_b5", 2'd0, 11'h005, 32'h0000_0080);
        load("ld_b5s", 2'd0, 1'b1, 11'h005, 32'hFFFF_FF80);
        load("ld_b5u", 2'd0, 1'b0, 11'h005, 32'h0000_0080);
        load("ld_w4b", 2'd2, 1'b0, 11'h004, 32'hDEAD_80EF);

        // half store across the wrap point
        store("st_h7ff", 2'd1, 11'h7FF, 32'h0000_1234);
        load("ld_h7ffu", 2'd1, 1'b0, 11'h7FF, 32'h0000_1234);
        load("ld_b0", 2'd0, 1'b0, 11'h000, 32'h0000_0012);
        load("ld_w7fc", 2'd2, 1'b0, 11'h7FC, 32'h3400_0000);
        load("ld_w0", 2'd2, 1'b0, 11'h000, 32'h0000_0012);

        // half store ignores upper data bits; signed/unsigned half loads
        store("st_h20", 2'd1, 11'h020, 32'hFFFF_8001);
        load("ld_h20s", 2'd1, 1'b1, 11'h020, 32'hFFFF_8001);
        load("ld_h20u", 2'd1, 1'b0, 11'h020, 32'h0000_8001);
        load("ld_w20", 2'd2, 1'b1, 11'h020, 32'h0000_8001);

        // reserved size behaves as word, signed flag ignored
        store("st_r30", 2'd3, 11'h030, 32'hCAFE_F00D);
        load("ld_r30", 2'd3, 1'b1, 11'h030, 32'hCAFE_F00D);
        load("ld_b33s", 2'd0, 1'b1, 11'h033, 32'hFFFF_FFCA);

        // response back-pressure
        issue("stall", 1'b0, 2'd2, 1'b0, 11'h004, 32'h0);
        step();
        check("stall_valid0", {31'd0, rsp_valid}, 32'd1);
        check("stall_data0", rsp_data, 32'hDEAD_80EF);
        held = rsp_data;
        for (int i = 0; i < 5; i++) begin
            step();
            check("stall_valid", {31'd0, rsp_valid}, 32'd1);
            check("stall_data", rsp_data, 32'hDEAD_80EF);
            check("stall_ready", {31'd0, req_ready}, 32'd0);
        end
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
        check("stall_idle", {31'd0, req_ready}, 32'd1);
        check("stall_rsp_gone", {31'd0, rsp_valid}, 32'd0);

        // back-to-back word store then load, req_valid held high
        req_write = 1'b1;
        req_size  = 2'd2;
        req_addr  = 11'h040;
        req_wdata = 32'h1122_3344;
        req_valid = 1'b1;
        wait_ready("b2b_st");
        step();
        check("b2b_ready_after_store", {31'd0, req_ready}, 32'd1);
        req_write = 1'b0;
        req_wdata = 32'h0;
        step();
        req_valid = 1'b0;
        check("b2b_n1_valid", {31'd0, rsp_valid}, 32'd0);
        step();
        check("b2b_n2_valid", {31'd0, rsp_valid}, 32'd1);
        check("b2b_data", rsp_data, 32'h1122_3344);
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;

        // reset during a merge drops the write
        store("st_w10", 2'd2, 11'h010, 32'h5566_7788);
        wren_seen = 0;
        mon_en    = 1'b1;
        issue("st_b10", 1'b1, 2'd0, 1'b0, 11'h010, 32'h0000_00AA);
        check("merge_state", {30'd0, dbg_state}, 32'd2);
        reset_n = 1'b0;
        #1;
        check("merge_rst_wren", {31'd0, mem_wren}, 32'd0);
        step();
        step();
        reset_n = 1'b1;
        step();
        mon_en = 1'b0;
        check("merge_rst_wren_seen", wren_seen, 32'd0);
        check("merge_rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        check("merge_rst_mem", rd_word(11'h010), 32'h5566_7788);
        load("ld_w10", 2'd2, 1'b0, 11'h010, 32'h5566_7788);

        // reset during a load discards the result
        issue("ld_rst", 1'b0, 2'd2, 1'b0, 11'h004, 32'h0);
        reset_n = 1'b0;
        step();
        check("ld_rst_valid", {31'd0, rsp_valid}, 32'd0);
        check("ld_rst_data", rsp_data, 32'h0);
        check("ld_rst_state", {30'd0, dbg_state}, 32'd0);
        reset_n = 1'b1;
        step();
        check("ld_rst_ready", {31'd0, req_ready}, 32'd1);
        check("ld_rst_no_rsp", {31'd0, rsp_valid}, 32'd0);
        load("ld_after_rst", 2'd1, 1'b1, 11'h006, 32'hFFFF_DEAD);

        // final report
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
